// File: rtl/data_path_if.sv
// rtl/data_path_if.sv - control/status bundle between the control automaton and data_path
interface data_path_if #(
  parameter int Y_WIDTH = 8,
  parameter int S_WIDTH = 5
);
  // micro-operation controls from the automaton
  logic [Y_WIDTH-1:0] x;
  logic               s_en;
  logic               s_zero;
  logic               s_add;
  logic [1:0]         s_step;
  logic               y_en;
  logic               y_store_x;
  logic [1:0]         y_select_next;

  // status and observation outputs of the operational unit
  logic               s_is_zero;
  logic [S_WIDTH-1:0] s_out;
  logic [Y_WIDTH-1:0] y_out;
  logic               y_valid;
  logic               s_wrap;

  // controller side: drives micro-ops, observes status
  modport master (
    output x, s_en, s_zero, s_add, s_step, y_en, y_store_x, y_select_next,
    input  s_is_zero, s_out, y_out, y_valid, s_wrap
  );

  // datapath side: executes micro-ops, reports status
  modport slave (
    input  x, s_en, s_zero, s_add, s_step, y_en, y_store_x, y_select_next,
    output s_is_zero, s_out, y_out, y_valid, s_wrap
  );
endinterface

// File: rtl/data_path.sv
// rtl/data_path.sv - step register s and result register y executing per-cycle micro-ops
module data_path #(
  parameter int Y_WIDTH = 8,
  parameter int S_WIDTH = 5
) (
  input  logic       clk,
  input  logic       rst,
  data_path_if.slave bus
);

  // y next-value function codes
  localparam logic [1:0] YSEL_HOLD = 2'd0;
  localparam logic [1:0] YSEL_INC  = 2'd1;
  localparam logic [1:0] YSEL_INV  = 2'd2;
  localparam logic [1:0] YSEL_ROTL = 2'd3;

  logic [S_WIDTH-1:0] r_s;
  logic [Y_WIDTH-1:0] r_y;
  logic               r_y_valid;
  logic               r_s_wrap;

  logic [S_WIDTH-1:0] w_s_base;
  logic [S_WIDTH:0]   w_s_base_ext;
  logic [S_WIDTH:0]   w_s_step_ext;
  logic [S_WIDTH:0]   w_s_result;
  logic               w_s_wrap;
  logic [Y_WIDTH-1:0] w_y_next;

  // s operand: either zero or the current step register
  assign w_s_base     = bus.s_zero ? '0 : r_s;
  assign w_s_base_ext = {1'b0, w_s_base};
  assign w_s_step_ext = {{(S_WIDTH-1){1'b0}}, bus.s_step};

  // one guard bit catches both carry-out on add and borrow on subtract,
  // since neither the base nor the step can exceed its own range
  always_comb begin
    w_s_result = w_s_base_ext;
    if (bus.s_add) begin
      w_s_result = w_s_base_ext + w_s_step_ext;
    end else begin
      w_s_result = w_s_base_ext - w_s_step_ext;
    end
  end

  assign w_s_wrap = w_s_result[S_WIDTH];

  // y next value: store of x has priority over the select function
  always_comb begin
    w_y_next = r_y;
    if (bus.y_store_x) begin
      w_y_next = bus.x;
    end else begin
      case (bus.y_select_next)
        YSEL_HOLD: w_y_next = r_y;
        YSEL_INC:  w_y_next = r_y + {{(Y_WIDTH-1){1'b0}}, 1'b1};
        YSEL_INV:  w_y_next = ~r_y;
        YSEL_ROTL: w_y_next = {r_y[Y_WIDTH-2:0], r_y[Y_WIDTH-1]};
        default:   w_y_next = r_y;
      endcase
    end
  end

  // step register update and its wrap strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s      <= '0;
      r_s_wrap <= 1'b0;
    end else begin
      r_s_wrap <= bus.s_en & w_s_wrap;
      if (bus.s_en) begin
        r_s <= w_s_result[S_WIDTH-1:0];
      end
    end
  end

  // result register update; valid strobe follows every write, hold included
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_y_valid <= bus.y_en;
      if (bus.y_en) begin
        r_y <= w_y_next;
      end
    end
  end

  // status is decoded from the register alone so the controller can use it
  // in the same cycle without a loop through its own control outputs
  assign bus.s_is_zero = (r_s == '0);
  assign bus.s_out     = r_s;
  assign bus.y_out     = r_y;
  assign bus.y_valid   = r_y_valid;
  assign bus.s_wrap    = r_s_wrap;

endmodule

// File: tb/tb_data_path.sv
// tb/tb_data_path.sv - directed self-checking bench for data_path
module tb_data_path;

  localparam int YW = 8;
  localparam int SW = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  data_path_if #(.Y_WIDTH(YW), .S_WIDTH(SW)) bus ();

  data_path #(.Y_WIDTH(YW), .S_WIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // all controls inactive
  task automatic idle();
    bus.x             = '0;
    bus.s_en          = 1'b0;
    bus.s_zero        = 1'b0;
    bus.s_add         = 1'b0;
    bus.s_step        = 2'd0;
    bus.y_en          = 1'b0;
    bus.y_store_x     = 1'b0;
    bus.y_select_next = 2'd0;
  endtask

  // one rising edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s_op(input logic zero, input logic add, input logic [1:0] step);
    bus.s_en   = 1'b1;
    bus.s_zero = zero;
    bus.s_add  = add;
    bus.s_step = step;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    // power-on reset values
    if (bus.s_out !== 5'd0 || bus.y_out !== 8'd0 || bus.s_is_zero !== 1'b1 ||
        bus.y_valid !== 1'b0 || bus.s_wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_por: s=%0d y=%h z=%b v=%b w=%b, want s=0 y=00 z=1 v=0 w=0",
               bus.s_out, bus.y_out, bus.s_is_zero, bus.y_valid, bus.s_wrap);
    end
    checks++;
    rst = 1'b0;
    tick();
    // build s=13, y=A5 with y_valid high
    idle(); s_op(1'b1, 1'b1, 2'd3); tick();
    s_op(1'b0, 1'b1, 2'd3); tick();
    tick();
    tick();
    s_op(1'b0, 1'b1, 2'd1);
    bus.y_en = 1'b1; bus.y_store_x = 1'b1; bus.x = 8'hA5;
    tick();
    idle();
    bus.y_en = 1'b1; bus.y_select_next = 2'd0;
    if (bus.s_out !== 5'd13 || bus.y_out !== 8'hA5 || bus.y_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_setup: s=%0d y=%h v=%b, want s=13 y=a5 v=1",
               bus.s_out, bus.y_out, bus.y_valid);
    end
    checks++;
    // asynchronous assertion between edges
    #1;
    rst = 1'b1;
    #1;
    if (bus.s_out !== 5'd0 || bus.y_out !== 8'd0 || bus.s_is_zero !== 1'b1 ||
        bus.y_valid !== 1'b0 || bus.s_wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: s=%0d y=%h z=%b v=%b w=%b, want s=0 y=00 z=1 v=0 w=0",
               bus.s_out, bus.y_out, bus.s_is_zero, bus.y_valid, bus.s_wrap);
    end
    checks++;
    idle();
    #1;
    rst = 1'b0;
  endtask

  task automatic test_enumeration();
    logic [4:0] exp_s [5];
    exp_s[0] = 5'd1; exp_s[1] = 5'd3; exp_s[2] = 5'd5; exp_s[3] = 5'd7; exp_s[4] = 5'd1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0 || i == 4) s_op(1'b1, 1'b1, 2'd1);
      else                  s_op(1'b0, 1'b1, 2'd2);
      tick();
      if (bus.s_out !== exp_s[i] || bus.s_wrap !== 1'b0) begin
        errors++;
        $display("FAIL enum_%0d: s=%0d w=%b, want s=%0d w=0", i, bus.s_out, bus.s_wrap, exp_s[i]);
      end
      checks++;
    end
    idle();
  endtask

  task automatic test_countdown();
    int ms;
    int wraps;
    int valids;
    logic exp_w;
    do_reset();
    ms = 0; wraps = 0; valids = 0;
    for (int i = 0; i < 64; i++) begin
      s_op(1'b0, 1'b0, 2'd1);
      bus.y_en          = bus.s_is_zero;
      bus.y_select_next = 2'd1;
      exp_w = (ms == 0);
      ms    = (ms + 31) % 32;
      tick();
      if (bus.s_out !== 5'(ms) || bus.s_wrap !== exp_w) begin
        errors++;
        $display("FAIL count_cyc%0d: s=%0d w=%b, want s=%0d w=%b", i, bus.s_out, bus.s_wrap, ms, exp_w);
      end
      checks++;
      if (bus.s_wrap === 1'b1) wraps++;
      if (bus.y_valid === 1'b1) valids++;
    end
    idle();
    if (bus.y_out !== 8'd2 || valids != 2 || wraps != 2) begin
      errors++;
      $display("FAIL count_total: y=%0d valid_pulses=%0d wrap_pulses=%0d, want 2 2 2",
               bus.y_out, valids, wraps);
    end
    checks++;
  endtask

  task automatic test_refresh();
    do_reset();
    bus.x = 8'h81; bus.y_en = 1'b1; bus.y_store_x = 1'b1;
    tick();
    if (bus.y_out !== 8'h81 || bus.y_valid !== 1'b1 || bus.s_out !== 5'd0) begin
      errors++;
      $display("FAIL refresh_store: y=%h v=%b s=%0d, want y=81 v=1 s=0", bus.y_out, bus.y_valid, bus.s_out);
    end
    checks++;
    idle();
    bus.y_en = 1'b1; bus.y_select_next = 2'd3;
    s_op(1'b0, 1'b1, 2'd1);
    tick();
    if (bus.y_out !== 8'h03 || bus.y_valid !== 1'b1 || bus.s_out !== 5'd1) begin
      errors++;
      $display("FAIL refresh_rotl: y=%h v=%b s=%0d, want y=03 v=1 s=1", bus.y_out, bus.y_valid, bus.s_out);
    end
    checks++;
    idle();
  endtask

  task automatic test_overflow_priority();
    // s=1: 1-3 underflows to 30
    s_op(1'b0, 1'b0, 2'd3); tick();
    if (bus.s_out !== 5'd30 || bus.s_wrap !== 1'b1) begin
      errors++;
      $display("FAIL underflow: s=%0d w=%b, want s=30 w=1", bus.s_out, bus.s_wrap);
    end
    checks++;
    s_op(1'b0, 1'b1, 2'd3); tick();
    if (bus.s_out !== 5'd1 || bus.s_wrap !== 1'b1) begin
      errors++;
      $display("FAIL overflow: s=%0d w=%b, want s=1 w=1", bus.s_out, bus.s_wrap);
    end
    checks++;
    s_op(1'b0, 1'b0, 2'd1); tick();
    if (bus.s_out !== 5'd0 || bus.s_wrap !== 1'b0 || bus.s_is_zero !== 1'b1) begin
      errors++;
      $display("FAIL to_zero: s=%0d w=%b z=%b, want s=0 w=0 z=1", bus.s_out, bus.s_wrap, bus.s_is_zero);
    end
    checks++;
    // s=0 minus 0 and then 31+0 are exact boundaries without wrap
    s_op(1'b0, 1'b0, 2'd0); tick();
    s_op(1'b0, 1'b0, 2'd1); tick();
    s_op(1'b0, 1'b1, 2'd0); tick();
    if (bus.s_out !== 5'd31 || bus.s_wrap !== 1'b0) begin
      errors++;
      $display("FAIL edge_31: s=%0d w=%b, want s=31 w=0", bus.s_out, bus.s_wrap);
    end
    checks++;
    idle();
    bus.x = 8'h5C; bus.y_en = 1'b1; bus.y_store_x = 1'b1; bus.y_select_next = 2'd2;
    tick();
    if (bus.y_out !== 8'h5C) begin
      errors++;
      $display("FAIL store_prio: y=%h, want 5c", bus.y_out);
    end
    checks++;
    bus.y_store_x = 1'b0; tick();
    if (bus.y_out !== 8'hA3) begin
      errors++;
      $display("FAIL invert: y=%h, want a3", bus.y_out);
    end
    checks++;
    bus.x = 8'hFF; bus.y_store_x = 1'b1; tick();
    bus.y_store_x = 1'b0; bus.y_select_next = 2'd1; tick();
    if (bus.y_out !== 8'h00 || bus.s_wrap !== 1'b0) begin
      errors++;
      $display("FAIL inc_wrap: y=%h w=%b, want y=00 w=0", bus.y_out, bus.s_wrap);
    end
    checks++;
    idle();
    s_op(1'b1, 1'b1, 2'd2); bus.x = 8'h96; bus.y_en = 1'b1; bus.y_store_x = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_hold();
    // s=2, y=96 going in
    for (int i = 0; i < 20; i++) begin
      bus.x             = 8'($urandom);
      bus.s_zero        = 1'($urandom);
      bus.s_add         = 1'($urandom);
      bus.s_step        = 2'($urandom_range(3));
      bus.y_store_x     = 1'($urandom);
      bus.y_select_next = 2'($urandom_range(3));
      bus.s_en          = 1'b0;
      bus.y_en          = 1'b0;
      #1;
      if (bus.s_is_zero !== 1'b0) begin
        errors++;
        $display("FAIL no_comb_path_%0d: z=%b, want 0", i, bus.s_is_zero);
      end
      checks++;
      tick();
      if (bus.s_out !== 5'd2 || bus.y_out !== 8'h96 || bus.y_valid !== 1'b0 || bus.s_wrap !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: s=%0d y=%h v=%b w=%b, want s=2 y=96 v=0 w=0",
                 i, bus.s_out, bus.y_out, bus.y_valid, bus.s_wrap);
      end
      checks++;
    end
    idle();
    bus.y_en = 1'b1; bus.y_select_next = 2'd0;
    tick();
    if (bus.y_out !== 8'h96 || bus.y_valid !== 1'b1 || bus.s_out !== 5'd2) begin
      errors++;
      $display("FAIL hold_write: y=%h v=%b s=%0d, want y=96 v=1 s=2", bus.y_out, bus.y_valid, bus.s_out);
    end
    checks++;
    idle();
    tick();
    if (bus.y_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_drop: v=%b, want 0", bus.y_valid);
    end
    checks++;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle();
    #2;
    test_reset();
    test_enumeration();
    test_countdown();
    test_refresh();
    test_overflow_priority();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
